// File: rtl/dsc_pkg.sv
// Shared constants and helpers for the digital sample channel: command opcodes,
// sample-word layout and the run-state encoding.
package dsc_pkg;

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_SETDIV = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned OVF_BIT   = 30;
    localparam int unsigned TS_LSB    = 1;
    localparam int unsigned TS_WIDTH  = 29;
    localparam int unsigned VAL_BIT   = 0;

    localparam int unsigned DIV_WIDTH = 24;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_CHANGE   = 1'b1;

    function automatic logic [31:0] pack_sample(input logic                ovf,
                                                input logic [TS_WIDTH-1:0] ts,
                                                input logic                val);
        logic [31:0] word;
        word                     = '0;
        word[VALID_BIT]          = 1'b1;
        word[OVF_BIT]            = ovf;
        word[TS_LSB +: TS_WIDTH] = ts;
        word[VAL_BIT]            = val;
        return word;
    endfunction

endpackage

// File: rtl/sample_buffer.sv
// Synchronous show-ahead FIFO: the oldest entry is always presented on head.
// A flush empties it regardless of a push or pop in the same cycle.
module sample_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so push while full is legal with a pop.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/digital_sample_channel.sv
// Timestamped digital pin sampler: periodic or on-change capture into a local FIFO,
// drained by the sample collector over a wired-OR bus.
module digital_sample_channel
    import dsc_pkg::*;
#(
    parameter int unsigned POSITION = 0,
    parameter int unsigned CHANNEL  = 0,
    parameter int unsigned DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] addr,
    input  logic        data_wr,
    input  logic [31:0] data_in,
    input  logic        pin,
    input  logic        output_sample,
    input  logic [7:0]  channel_select,
    output logic [31:0] sample_data,
    input  logic [31:0] current_time
);

    localparam logic [15:0] MY_ADDR = 16'(POSITION);
    localparam logic [7:0]  MY_CHAN = 8'(CHANNEL);

    logic                 state_q, state_d;
    logic                 mode_q, mode_d;
    logic [DIV_WIDTH-1:0] divider_q, divider_d;
    logic [DIV_WIDTH-1:0] counter_q, counter_d;
    logic                 ovf_q, ovf_d;
    logic                 sync1_q, pin_s, pin_d;

    logic        cmd_hit;
    logic [1:0]  opcode;
    logic        flush;
    logic        tick;
    logic        capture;
    logic        selected;
    logic        pop;
    logic        push;
    logic        full;
    logic        empty;
    logic [31:0] head;
    logic [31:0] new_word;
    logic        unused_bits;

    assign unused_bits = ^{current_time[31:TS_WIDTH], data_in[29:DIV_WIDTH]};

    assign cmd_hit  = enable && data_wr && (addr == MY_ADDR);
    assign opcode   = data_in[31:30];
    assign flush    = cmd_hit && (opcode == OP_FLUSH);
    assign tick     = (counter_q == divider_q);
    assign capture  = (state_q == ST_RUN) &&
                      ((mode_q == MODE_CHANGE) ? (pin_s != pin_d) : tick);
    assign selected = (channel_select == MY_CHAN);
    assign pop      = output_sample && selected && !empty;
    assign push     = capture && (!full || pop);
    assign new_word = pack_sample(ovf_q, current_time[TS_WIDTH-1:0], pin_s);

    // Must be all zeros when not driving: the bus is wired-OR across channels.
    assign sample_data = (selected && !empty) ? head : 32'h0;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        divider_d = divider_q;
        counter_d = counter_q;
        ovf_d     = ovf_q;

        if (state_q == ST_RUN && mode_q == MODE_PERIODIC) begin
            counter_d = tick ? '0 : counter_q + DIV_WIDTH'(1);
        end

        // Commands override the free-running counter update above.
        if (cmd_hit) begin
            unique case (opcode)
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                OP_START: begin
                    state_d   = ST_RUN;
                    mode_d    = data_in[0];
                    counter_d = '0;
                end
                OP_SETDIV: begin
                    divider_d = data_in[DIV_WIDTH-1:0];
                    if (state_q == ST_RUN) begin
                        counter_d = '0;
                    end
                end
                OP_FLUSH: begin
                end
            endcase
        end

        // The sticky flag rides out in the next accepted word, then clears.
        if (flush || push) begin
            ovf_d = 1'b0;
        end else if (capture) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_PERIODIC;
            divider_q <= '0;
            counter_q <= '0;
            ovf_q     <= 1'b0;
            sync1_q   <= 1'b0;
            pin_s     <= 1'b0;
            pin_d     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            divider_q <= divider_d;
            counter_q <= counter_d;
            ovf_q     <= ovf_d;
            sync1_q   <= pin;
            pin_s     <= sync1_q;
            pin_d     <= pin_s;
        end
    end

    sample_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (new_word),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_digital_sample_channel.sv
// Directed self-checking bench for digital_sample_channel.
module tb_digital_sample_channel;

    localparam int unsigned POS   = 5;
    localparam int unsigned CH    = 3;
    localparam int unsigned DEPTH = 16;

    localparam logic [31:0] C_STOP   = 32'h0000_0000;
    localparam logic [31:0] C_START  = 32'h4000_0000;
    localparam logic [31:0] C_SETDIV = 32'h8000_0000;
    localparam logic [31:0] C_FLUSH  = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] addr = '0;
    logic        data_wr = 1'b0;
    logic [31:0] data_in = '0;
    logic        pin = 1'b0;
    logic        output_sample = 1'b0;
    logic [7:0]  channel_select = '0;
    logic [31:0] sample_data;
    logic [31:0] current_time = 32'h1FFF_FFF0;

    int checks = 0;
    int errors = 0;

    digital_sample_channel #(
        .POSITION (POS),
        .CHANNEL  (CH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .addr           (addr),
        .data_wr        (data_wr),
        .data_in        (data_in),
        .pin            (pin),
        .output_sample  (output_sample),
        .channel_select (channel_select),
        .sample_data    (sample_data),
        .current_time   (current_time)
    );

    always #5 clk = ~clk;
    always @(posedge clk) current_time <= current_time + 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic ovf, input logic [31:0] t,
                                             input logic v);
        return {1'b1, ovf, t[28:0], v};
    endfunction

    // Valid, overflow and value bits only, for words whose timestamp is not tracked.
    function automatic logic [31:0] flags(input logic [31:0] w);
        return {29'd0, w[31], w[30], w[0]};
    endfunction

    task automatic cmd(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        enable  = 1'b1;
        data_wr = 1'b1;
        addr    = a;
        data_in = d;
        @(negedge clk);
        enable  = 1'b0;
        data_wr = 1'b0;
    endtask

    task automatic pop(output logic [31:0] w);
        @(negedge clk);
        channel_select = 8'(CH);
        output_sample  = 1'b1;
        #1 w = sample_data;
        @(negedge clk);
        output_sample = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] t1;

        // Reset; pops on an empty buffer read zero and change nothing.
        channel_select = 8'(CH);
        pin = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 check("reset_idle", sample_data, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pop(w);
            check("empty_pop", w, 32'h0);
        end

        // A START to another address must not start capturing.
        cmd(16'(POS + 1), C_START);
        repeat (3) @(negedge clk);
        #1 check("wrong_addr", sample_data, 32'h0);

        // Periodic, divider 4: five captures in 25 cycles, 5 apart.
        cmd(16'(POS), C_SETDIV | 32'd4);
        cmd(16'(POS), C_START);
        t1 = current_time;
        repeat (24) @(negedge clk);
        cmd(16'(POS), C_STOP);
        for (int k = 0; k < 5; k++) begin
            pop(w);
            check($sformatf("periodic_%0d", k), w, exp_word(1'b0, t1 + 32'(4 + 5 * k), 1'b1));
        end
        pop(w);
        check("periodic_drained", w, 32'h0);

        // On-change: 20 toggles into a 16-deep buffer, then overflow reporting.
        cmd(16'(POS), C_START | 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pin = ~pin;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        pop(w);
        check("change_0", flags(w), 32'b100);
        @(negedge clk);
        pin = ~pin;
        repeat (5) @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            pop(w);
            check($sformatf("change_%0d", i), flags(w), {29'd0, 2'b10, 1'(i % 2)});
        end
        pop(w);
        check("change_ovf_set", flags(w), 32'b110);
        pop(w);
        check("change_drained", w, 32'h0);
        @(negedge clk);
        pin = ~pin;
        repeat (5) @(negedge clk);
        pop(w);
        check("change_ovf_clear", flags(w), 32'b101);
        cmd(16'(POS), C_STOP);

        // Divider 0 into a full buffer with a pop every cycle: nothing may be dropped.
        cmd(16'(POS), C_SETDIV);
        cmd(16'(POS), C_START);
        t1 = current_time;
        repeat (16) @(negedge clk);
        channel_select = 8'(CH);
        output_sample  = 1'b1;
        repeat (5) @(negedge clk);
        enable  = 1'b1;
        data_wr = 1'b1;
        addr    = 16'(POS);
        data_in = C_STOP;
        @(negedge clk);
        enable        = 1'b0;
        data_wr       = 1'b0;
        output_sample = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pop(w);
            check($sformatf("full_%0d", i), w, exp_word(1'b0, t1 + 32'(6 + i), 1'b1));
        end
        pop(w);
        check("full_drained", w, 32'h0);

        // One capture after the full test must carry no stale overflow.
        cmd(16'(POS), C_SETDIV | 32'd2);
        cmd(16'(POS), C_START);
        t1 = current_time;
        repeat (3) @(negedge clk);
        cmd(16'(POS), C_STOP);

        // Channel select gates the wired-OR output combinationally.
        @(negedge clk);
        channel_select = 8'(CH + 1);
        #1 check("other_channel", sample_data, 32'h0);
        channel_select = 8'(CH);
        #1 check("own_channel", sample_data, exp_word(1'b0, t1 + 32'd2, 1'b1));
        pop(w);
        check("own_channel_pop", w, exp_word(1'b0, t1 + 32'd2, 1'b1));
        pop(w);
        check("own_channel_drained", w, 32'h0);

        // FLUSH colliding with capture and pop leaves the buffer empty, RUN continues.
        cmd(16'(POS), C_SETDIV);
        cmd(16'(POS), C_START);
        repeat (3) @(negedge clk);
        enable         = 1'b1;
        data_wr        = 1'b1;
        addr           = 16'(POS);
        data_in        = C_FLUSH;
        channel_select = 8'(CH);
        output_sample  = 1'b1;
        @(negedge clk);
        enable        = 1'b0;
        data_wr       = 1'b0;
        output_sample = 1'b0;
        #1 check("flush_empty", sample_data, 32'h0);
        @(negedge clk);
        #1 check("flush_still_run", flags(sample_data), 32'b101);

        // Reset mid-RUN discards samples and returns to IDLE with divider 0, periodic.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_empty", sample_data, 32'h0);
        pin = 1'b0;
        repeat (8) @(negedge clk);
        #1 check("reset_idle_nocap", sample_data, 32'h0);
        cmd(16'(POS), C_START);
        #1 check("restart_latency", sample_data, 32'h0);
        @(negedge clk);
        #1 check("restart_div0", flags(sample_data), 32'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
